mdu_seq: RTL and testbench



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_sign_fix.sv | 15 +
 rtl/mdu_seq.sv | 143 ++++++++++++++
 tb/tb_mdu_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the iterative multiply/divide unit.
//   - op encodings driven on mdu_seq.op
//   - FSM state type
//   - LO/HI write-enable codes
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    localparam logic [1:0] WEN_NONE = 2'b00;
    localparam logic [1:0] WEN_BOTH = 2'b11;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negation.
//   i_val  in   W  value
//   i_neg  in   1  negate when high
//   o_val  out  W  i_neg ? -i_val : i_val
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU unit, writer of the LO/HI pair.
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous active-high reset
//   start  in   1  launch request, honoured in IDLE only
//   op     in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   W  dividend / multiplicand
//   b      in   W  divisor / multiplier
//   busy   out  1  unit occupied (CALC, SIGN, DONE)
//   done   out  1  one-cycle completion pulse
//   wen    out  2  LO/HI write enable, 11 in DONE
//   wLO    out  W  product low word / quotient
//   wHI    out  W  product high word / remainder
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int W     = 32,
    parameter int ITERS = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [1:0]   wen,
    output logic [W-1:0] wLO,
    output logic [W-1:0] wHI
);

    localparam logic [5:0] LAST = 6'(ITERS - 1);

    state_t         r_state, w_next;
    logic [5:0]     r_cnt;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_bm;
    logic [1:0]     r_op;
    logic           r_sa, r_sb;
    logic [W-1:0]   r_wlo, r_whi;

    logic           w_sgn_in, w_div0;
    logic [W-1:0]   w_amag, w_bmag;
    logic [W:0]     w_mul_sum, w_rem, w_diff;
    logic [2*W-1:0] w_mul_step, w_div_step;
    logic [W-1:0]   w_lo, w_hi, w_hi_in, w_lo_fix, w_hi_fix;
    logic           w_is_mul, w_neg_q;

    assign w_sgn_in = ~op[0];
    assign w_div0   = op[1] && (b == '0);

    mdu_sign_fix #(.W(W)) u_amag (.i_val(a), .i_neg(w_sgn_in & a[W-1]), .o_val(w_amag));
    mdu_sign_fix #(.W(W)) u_bmag (.i_val(b), .i_neg(w_sgn_in & b[W-1]), .o_val(w_bmag));

    // Multiply step: add multiplicand into the high half on LSB, then shift right
    // with the carry entering at the top.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_bm};
    assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};

    // Restoring divide step on the shifted remainder; borrow means restore.
    assign w_rem      = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff     = w_rem - {1'b0, r_bm};
    assign w_div_step = w_diff[W] ? {w_rem[W-1:0], r_acc[W-2:0], 1'b0}
                                  : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

    // 2W-bit negation built from two W-bit negators: -{HI,LO} has LO' = -LO and
    // HI' = ~HI + (LO==0); ~HI equals -(HI+1), so HI+1 feeds the HI negator.
    assign w_lo     = r_acc[W-1:0];
    assign w_hi     = r_acc[2*W-1:W];
    assign w_is_mul = ~r_op[1];
    assign w_neg_q  = r_sa ^ r_sb;
    assign w_hi_in  = (w_is_mul && w_neg_q && (w_lo != '0)) ? (w_hi + W'(1)) : w_hi;

    mdu_sign_fix #(.W(W)) u_lofix (.i_val(w_lo), .i_neg(w_neg_q), .o_val(w_lo_fix));
    mdu_sign_fix #(.W(W)) u_hifix (.i_val(w_hi_in), .i_neg(w_is_mul ? w_neg_q : r_sa), .o_val(w_hi_fix));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_div0 ? DONE : CALC;
            CALC:    if (r_cnt == LAST) w_next = SIGN;
            SIGN:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_bm  <= '0;
            r_op  <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_wlo <= '0;
            r_whi <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_sa  <= w_sgn_in & a[W-1];
                        r_sb  <= w_sgn_in & b[W-1];
                        r_cnt <= '0;
                        if (op[1]) begin
                            r_acc <= {{W{1'b0}}, w_amag};
                            r_bm  <= w_bmag;
                        end else begin
                            r_acc <= {{W{1'b0}}, w_bmag};
                            r_bm  <= w_amag;
                        end
                        if (w_div0) begin
                            r_wlo <= '1;
                            r_whi <= a;
                        end
                    end
                end
                CALC: begin
                    r_acc <= r_op[1] ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 6'd1;
                end
                SIGN: begin
                    r_wlo <= w_lo_fix;
                    r_whi <= w_hi_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign wen  = done ? WEN_BOTH : WEN_NONE;
    assign wLO  = r_wlo;
    assign wHI  = r_whi;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [1:0]  wen;
    logic [31:0] wLO, wHI;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu_seq #(.W(32), .ITERS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .wen(wen), .wLO(wLO), .wHI(wHI)
    );

    // Reference: {HI,LO} straight from integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
        logic signed [63:0] sx, sy;
        logic signed [31:0] qa, qb;
        logic [63:0] r;
        sx = $signed(f_a);
        sy = $signed(f_b);
        qa = f_a;
        qb = f_b;
        case (f_op)
            2'b00: r = sx * sy;
            2'b01: r = {32'h0, f_a} * {32'h0, f_b};
            2'b10: begin
                if (f_b == 0) r = {f_a, 32'hFFFF_FFFF};
                else if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else r = {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (f_b == 0) r = {f_a, 32'hFFFF_FFFF};
                else r = {f_a % f_b, f_a / f_b};
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b, input string tag);
        logic [63:0] exp_r;
        int exp_lat, k, busy_low;
        exp_r   = ref_model(t_op, t_a, t_b);
        exp_lat = (t_op[1] && t_b == 0) ? 1 : 34;
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        busy_low = 0;
        while (wen === 2'b00 && k < 40) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, k, exp_lat); end
        n_cmp++;
        if (busy_low != 0) begin n_bad++; $display("FAIL %s busy_gap: got %0d low cycles want 0", tag, busy_low); end
        n_cmp++;
        if (wen !== 2'b11 || done !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL %s done_cycle: wen=%b done=%b busy=%b want 11/1/1", tag, wen, done, busy);
        end
        n_cmp++;
        if ({wHI, wLO} !== exp_r) begin
            n_bad++; $display("FAIL %s result: HI:LO=%h:%h want %h:%h", tag, wHI, wLO, exp_r[63:32], exp_r[31:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (wen !== 2'b00 || done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL %s after_done: wen=%b done=%b busy=%b want 00/0/0", tag, wen, done, busy);
        end
        n_cmp++;
        if ({wHI, wLO} !== exp_r) begin
            n_bad++; $display("FAIL %s hold: HI:LO=%h:%h want %h:%h", tag, wHI, wLO, exp_r[63:32], exp_r[31:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || wen !== 2'b00 || wLO !== 32'h0 || wHI !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b wen=%b LO=%h HI=%h want 0/0/00/0/0", busy, done, wen, wLO, wHI);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_neg7by2");
        run_op(2'b11, 32'd100,       32'd7,         "divu_100by7");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(2'b11, 32'd5,         32'd0,         "divu_by0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0,         "div_neg_by0");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    endtask

    task automatic test_busy_ignore();
        logic [63:0] exp_r;
        int busy_low;
        exp_r = ref_model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        busy_low = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            if (k <= 34 && busy !== 1'b1) busy_low++;
            if (k == 34) begin
                n_cmp++;
                if (wen !== 2'b11 || {wHI, wLO} !== exp_r) begin
                    n_bad++; $display("FAIL ignore_first_result: wen=%b HI:LO=%h:%h want 11 %h", wen, wHI, wLO, exp_r);
                end
            end
            if (k >= 35) begin
                n_cmp++;
                if (busy !== 1'b0 || wen !== 2'b00) begin
                    n_bad++; $display("FAIL ignore_no_relaunch k=%0d: busy=%b wen=%b want 0/00", k, busy, wen);
                end
            end
            start = (k == 5 || k == 34);
            if (k == 5)  begin op = 2'b11; a = 32'd99; b = 32'd3; end
            if (k == 34) begin op = 2'b00; a = 32'd11; b = 32'd13; end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (busy_low != 0) begin n_bad++; $display("FAIL ignore_busy_span: got %0d low cycles want 0", busy_low); end
    endtask

    task automatic test_reset_mid();
        int wen_seen;
        wen_seen = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = $urandom; b = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (wen !== 2'b00) wen_seen++;
            if (k == 20) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: busy=%b want 1", busy); end
            end
            if (k == 21) begin
                n_cmp++;
                if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: busy=%b want 0", busy); end
            end
            rst = (k == 20);
            @(negedge clk);
        end
        rst = 1'b0;
        n_cmp++;
        if (wen_seen != 0) begin n_bad++; $display("FAIL rst_mid_nowrite: got %0d write cycles want 0", wen_seen); end
        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_with_start: busy=%b want 0", busy); end
        run_op(2'b00, $urandom, $urandom, "after_rst");
    endtask

    task automatic test_random();
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        int sel;
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            sel  = $urandom_range(0, 9);
            case (sel)
                0: r_b = 32'h0;
                1: r_a = 32'h8000_0000;
                2: r_b = 32'hFFFF_FFFF;
                3: r_b = 32'($urandom_range(1, 20));
                4: r_a = 32'h0;
                default: ;
            endcase
            run_op(r_op, r_a, r_b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
